// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if
// Groups the receiver-side frame handshake and the consumer-side FIFO
// handshake of uart_rx_buffer into one bundle.
//   master : the environment (receive FSM + consumer); drives rxFlag,
//            rxData, rxParity and outReady.
//   slave  : the buffer; drives rxFlagClr, outData, outValid, parErr,
//            overrun, errCnt and count.
// CW is the width of count and must match the buffer's CW.
interface uart_rx_buffer_if #(
  parameter int CW = 3
);
  logic          rxFlag;
  logic [7:0]    rxData;
  logic          rxParity;
  logic          rxFlagClr;
  logic [7:0]    outData;
  logic          outValid;
  logic          outReady;
  logic          parErr;
  logic          overrun;
  logic [7:0]    errCnt;
  logic [CW-1:0] count;

  modport master (
    output rxFlag, rxData, rxParity, outReady,
    input  rxFlagClr, outData, outValid, parErr, overrun, errCnt, count
  );

  modport slave (
    input  rxFlag, rxData, rxParity, outReady,
    output rxFlagClr, outData, outValid, parErr, overrun, errCnt, count
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Receive-side frame buffer behind the UART receive FSM. Captures one frame
// per rxFlag assertion, optionally checks even parity, stores good bytes in a
// DEPTH-entry show-ahead FIFO and acknowledges the receiver with the
// active-low rxFlagClr.
// Ports:
//   clk    : system clock, rising edge.
//   rst    : asynchronous, active-low reset.
//   rxBus  : uart_rx_buffer_if.slave (rxFlag/rxData/rxParity/rxFlagClr from
//            the receiver; outData/outValid/outReady to the consumer;
//            parErr/overrun pulses; errCnt; count occupancy).
// Parameters: DEPTH (power of two, >= 2), CW = log2(DEPTH)+1.
// Build option: define UART_RX_PARITY_CHECK_EN to drop parity-failed frames
// and report them on parErr/errCnt; otherwise every frame is stored and
// parErr/errCnt stay 0.
module uart_rx_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  uart_rx_buffer_if.slave rxBus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rxFlagClr_q, rxFlagClr_d;
  logic          overrun_q, overrun_d;
  logic          parErr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          capture, frameGood, fifoFull, pop, push;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. One capture per rxFlag assertion: ACK holds until the
  // receiver drops rxFlag. The unused encoding recovers to WAIT.
  always_comb begin
    state_d = WAIT;
    case (state_q)
      WAIT:    state_d = rxBus.rxFlag ? CAPTURE : WAIT;
      CAPTURE: state_d = ACK;
      ACK:     state_d = rxBus.rxFlag ? ACK : WAIT;
      default: state_d = WAIT;
    endcase
  end

`ifdef UART_RX_PARITY_CHECK_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign frameGood = ~(^{rxBus.rxData, rxBus.rxParity});
`else
  logic unusedParity;
  assign unusedParity = rxBus.rxParity;
  assign frameGood    = 1'b1;
`endif

  // Output logic. rxFlagClr is computed from the next state and registered,
  // so it is low exactly while the FSM sits in ACK. A full FIFO still accepts
  // a frame when the consumer pops in the same cycle.
  always_comb begin
    capture     = (state_q == CAPTURE);
    rxFlagClr_d = (state_d != ACK);
    fifoFull    = (count_q == CW'(DEPTH));
    pop         = (count_q != '0) && rxBus.outReady;
    push        = capture && frameGood && (!fifoFull || pop);
    overrun_d   = capture && frameGood && fifoFull && !pop;
    parErr_d    = capture && !frameGood;
  end

  // FIFO storage, pointers, occupancy and the registered handshake/pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxFlagClr_q <= 1'b1;
      overrun_q   <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      rxFlagClr_q <= rxFlagClr_d;
      overrun_q   <= overrun_d;
      if (push) begin
        mem_q[wrPtr_q] <= rxBus.rxData;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic       parErr_q;
  logic [7:0] errCnt_q;

  // Parity error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parErr_q <= 1'b0;
      errCnt_q <= 8'h00;
    end else begin
      parErr_q <= parErr_d;
      if (parErr_d && (errCnt_q != 8'hFF)) begin
        errCnt_q <= errCnt_q + 8'h01;
      end
    end
  end

  assign rxBus.parErr = parErr_q;
  assign rxBus.errCnt = errCnt_q;
`else
  logic unusedParErr;
  assign unusedParErr = parErr_d;
  assign rxBus.parErr = 1'b0;
  assign rxBus.errCnt = 8'h00;
`endif

  assign rxBus.rxFlagClr = rxFlagClr_q;
  assign rxBus.overrun   = overrun_q;
  assign rxBus.outData   = mem_q[rdPtr_q];
  assign rxBus.outValid  = (count_q != '0);
  assign rxBus.count     = count_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer
// Self-checking bench for uart_rx_buffer (DEPTH=4). A queue-based model of
// the frame buffer is compared against every output on each falling edge;
// directed scenarios add hand-computed literal expectations.
// Honours UART_RX_PARITY_CHECK_EN the same way as the design.
module tb_uart_rx_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_buffer_if #(.CW(CW)) bus ();

  uart_rx_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxBus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a byte queue plus the frame phase seen by the receiver.
  byte unsigned mq[$];
  bit           mPending = 1'b0;
  bit           mHolding = 1'b0;
  int           mErr = 0;
  bit           mParErr = 1'b0;
  bit           mOverrun = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mPending = 1'b0;
      mHolding = 1'b0;
      mErr     = 0;
      mParErr  = 1'b0;
      mOverrun = 1'b0;
    end else begin
      bit popNow;
      bit good;
      bit doPush;
      popNow   = bus.outReady && (mq.size() > 0);
      mParErr  = 1'b0;
      mOverrun = 1'b0;
      doPush   = 1'b0;
      if (mPending) begin
        good = !PCHK || ((^{bus.rxData, bus.rxParity}) == 1'b0);
        if (!good) begin
          mParErr = 1'b1;
          if (mErr < 255) mErr++;
        end else if ((mq.size() < DEPTH) || popNow) begin
          doPush = 1'b1;
        end else begin
          mOverrun = 1'b1;
        end
        mPending = 1'b0;
        mHolding = 1'b1;
      end else if (mHolding) begin
        if (!bus.rxFlag) mHolding = 1'b0;
      end else if (bus.rxFlag) begin
        mPending = 1'b1;
      end
      if (popNow) void'(mq.pop_front());
      if (doPush) mq.push_back(bus.rxData);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("cmpCount", 32'(bus.count), 32'(mq.size()));
      checkOutput("cmpValid", 32'(bus.outValid), 32'(mq.size() > 0));
      if (mq.size() > 0) checkOutput("cmpData", 32'(bus.outData), 32'(mq[0]));
      checkOutput("cmpFlagClr", 32'(bus.rxFlagClr), 32'(!mHolding));
      checkOutput("cmpParErr", 32'(bus.parErr), 32'(mParErr));
      checkOutput("cmpOverrun", 32'(bus.overrun), 32'(mOverrun));
      checkOutput("cmpErrCnt", 32'(bus.errCnt), PCHK ? 32'(mErr) : 32'd0);
    end
  end

  // Pulse counters for scenario-level expectations.
  int ovCount = 0;
  int peCount = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.overrun) ovCount++;
      if (bus.parErr)  peCount++;
    end
  end

  task automatic waitAckAndRelease(input int hold);
    int n = 0;
    while (bus.rxFlagClr && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rxFlagClr) begin
      errors++;
      $display("[TB] FAIL ackTimeout: rxFlagClr got 1, expected 0 within 8 cycles");
    end
    repeat (hold) @(negedge clk);
    bus.rxFlag = 1'b0;
    @(negedge clk);
  endtask

  // One receiver frame; optionally pops on the capture edge.
  task automatic applyStimulus(input logic [7:0] data, input logic par,
                               input int hold, input bit popOnCapture);
    @(negedge clk);
    bus.rxFlag   = 1'b1;
    bus.rxData   = data;
    bus.rxParity = par;
    @(negedge clk);
    bus.outReady = popOnCapture;
    @(negedge clk);
    bus.outReady = 1'b0;
    waitAckAndRelease(hold);
  endtask

  task automatic popExpect(input logic [7:0] expected);
    checkOutput("popValid", 32'(bus.outValid), 32'd1);
    checkOutput("popData", 32'(bus.outData), 32'(expected));
    bus.outReady = 1'b1;
    @(negedge clk);
    bus.outReady = 1'b0;
  endtask

  function automatic logic evenPar(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int ov0;
    int pe0;
    bus.rxFlag   = 1'b0;
    bus.rxData   = 8'h00;
    bus.rxParity = 1'b0;
    bus.outReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstFlagClr", 32'(bus.rxFlagClr), 32'd1);
    checkOutput("rstValid", 32'(bus.outValid), 32'd0);
    checkOutput("rstData", 32'(bus.outData), 32'h00);
    checkOutput("rstCount", 32'(bus.count), 32'd0);
    checkOutput("rstErrCnt", 32'(bus.errCnt), 32'd0);
    checkOutput("rstParErr", 32'(bus.parErr), 32'd0);
    checkOutput("rstOverrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single frame 0x5A");
    applyStimulus(8'h5A, 1'b0, 2, 1'b0);
    checkOutput("t1Valid", 32'(bus.outValid), 32'd1);
    checkOutput("t1Data", 32'(bus.outData), 32'h5A);
    checkOutput("t1Count", 32'(bus.count), 32'd1);
    popExpect(8'h5A);
    checkOutput("t1Empty", 32'(bus.outValid), 32'd0);

    $display("[TB] overrun on fifth frame");
    ov0 = ovCount;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), evenPar(8'(i)), 0, 1'b0);
    checkOutput("t2Count", 32'(bus.count), 32'd4);
    checkOutput("t2Overruns", 32'(ovCount - ov0), 32'd1);
    popExpect(8'h01);
    popExpect(8'h02);
    popExpect(8'h03);
    popExpect(8'h04);
    checkOutput("t2Empty", 32'(bus.count), 32'd0);

    $display("[TB] parity-bad frame");
    pe0 = peCount;
    applyStimulus(8'h01, 1'b0, 0, 1'b0);
    if (PCHK) begin
      checkOutput("t3Count", 32'(bus.count), 32'd0);
      checkOutput("t3ParErr", 32'(peCount - pe0), 32'd1);
      checkOutput("t3ErrCnt", 32'(bus.errCnt), 32'd1);
    end else begin
      checkOutput("t3Count", 32'(bus.count), 32'd1);
      checkOutput("t3ParErr", 32'(peCount - pe0), 32'd0);
      popExpect(8'h01);
    end

    $display("[TB] full FIFO with pop during capture");
    applyStimulus(8'h10, evenPar(8'h10), 0, 1'b0);
    applyStimulus(8'h20, evenPar(8'h20), 0, 1'b0);
    applyStimulus(8'h30, evenPar(8'h30), 0, 1'b0);
    applyStimulus(8'h40, evenPar(8'h40), 0, 1'b0);
    ov0 = ovCount;
    applyStimulus(8'hAA, 1'b0, 0, 1'b1);
    checkOutput("t4Count", 32'(bus.count), 32'd4);
    checkOutput("t4Overruns", 32'(ovCount - ov0), 32'd0);
    popExpect(8'h20);
    popExpect(8'h30);
    popExpect(8'h40);
    popExpect(8'hAA);

    $display("[TB] rxFlag held 20 cycles");
    applyStimulus(8'h33, 1'b0, 20, 1'b0);
    checkOutput("t5Count", 32'(bus.count), 32'd1);
    popExpect(8'h33);

    $display("[TB] reset during ACK");
    @(negedge clk);
    bus.rxFlag   = 1'b1;
    bus.rxData   = 8'h0F;
    bus.rxParity = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6PreCount", 32'(bus.count), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6FlagClr", 32'(bus.rxFlagClr), 32'd1);
    checkOutput("t6Count", 32'(bus.count), 32'd0);
    checkOutput("t6Valid", 32'(bus.outValid), 32'd0);
    checkOutput("t6Data", 32'(bus.outData), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    waitAckAndRelease(0);
    checkOutput("t6Recapture", 32'(bus.count), 32'd1);
    popExpect(8'h0F);

    $display("[TB] 300 parity-bad frames");
    for (int i = 0; i < 300; i++) applyStimulus(8'h01, 1'b0, 0, 1'b0);
    checkOutput("t7ErrCnt", 32'(bus.errCnt), PCHK ? 32'd255 : 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side frame buffer that sits directly downstream of the UART receive FSM. It captures each completed 8-bit frame plus parity bit when the receiver raises `rxFlag`, checks even parity, and stores good bytes in a small FIFO with a valid/ready output. It returns the active-low `rxFlagClr` acknowledge to the receiver, so the receiver stays in its read state until the frame has been taken.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `CW`, default 3: width of `count`, equal to log2(DEPTH)+1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rxFlag`  in  1  frame-complete flag from the receive FSM (high in its read state).
- `rxData`  in  8  received data byte, stable while `rxFlag`=1.
- `rxParity`  in  1  received parity bit, stable while `rxFlag`=1.
- `rxFlagClr`  out  1  active-low acknowledge to the receive FSM; 0 releases the receiver to idle.
- `outData`  out  8  FIFO head byte (show-ahead).
- `outValid`  out  1  FIFO non-empty.
- `outReady`  in  1  consumer pop request; a pop happens when `outValid`&`outReady`.
- `parErr`  out  1  one-cycle pulse on a parity-failed frame.
- `overrun`  out  1  one-cycle pulse on a frame lost to a full FIFO.
- `errCnt`  out  8  saturating count of parity-failed frames.
- `count`  out  CW  current FIFO occupancy.

## Operation
- Capture FSM, 2-bit state register, three states:
  - WAIT: `rxFlagClr`=1. Go to CAPTURE when `rxFlag`=1.
  - CAPTURE: one cycle. Evaluate the frame and push or drop it. Always go to ACK.
  - ACK: `rxFlagClr`=0. Stay while `rxFlag`=1. Go to WAIT when `rxFlag`=0.
  - Unused encoding goes to WAIT.
- Parity: the frame is good when the XOR of `rxData[7:0]` and `rxParity` equals 0 (even parity).
- Frame handling in CAPTURE:
  - Good frame, FIFO not full: push `rxData`.
  - Good frame, FIFO full, pop in the same cycle: push is accepted and `count` is unchanged.
  - Good frame, FIFO full, no pop: drop the byte and pulse `overrun` for one cycle.
  - Bad frame: see Configuration.
- FIFO: circular buffer, log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH, plus a CW-bit occupancy counter.
  - `count` changes by push minus pop.
  - Push and pop in the same cycle: `count` is unchanged.
  - Pop when empty is ignored (`outValid`=0).
- `outData` equals the memory at the read pointer. Its value is don't-care when `outValid`=0, but it resets to 0.
- `errCnt` saturates at 255.
- Reset values: `rxFlagClr`=1, `outValid`=0, `outData`=0, `parErr`=0, `overrun`=0, `errCnt`=0, `count`=0, pointers 0, state WAIT.
- Reset mid-operation discards FIFO contents and any frame in progress. After reset, a still-high `rxFlag` is treated as a new frame.

## Timing
- `rxFlag` rises before edge E. Then:
  - Edge E: enter CAPTURE.
  - Edge E+1: push/drop completes, `count`/`outValid` update, pulses assert. Enter ACK, so `rxFlagClr`=0 from E+1.
- Data visibility: a byte pushed at edge E+1 is visible on `outData`/`outValid` after E+1. Push-to-output latency is 2 cycles from `rxFlag` sampling.
- `rxFlagClr` is registered and glitch-free. It stays low until `rxFlag` is sampled 0, then returns to 1 on that edge.
- Each `rxFlag` assertion yields exactly one capture, however long `rxFlag` stays high.
- `parErr` and `overrun` are each exactly one cycle wide, aligned with the CAPTURE-exit edge.
- Pop: after a pop edge, the next entry appears on `outData` (or `outValid` drops) in the same cycle. Pop adds no latency.

## Configuration
- Macro `UART_RX_PARITY_CHECK_EN`.
- Defined:
  - Bad frames are not pushed.
  - `parErr` pulses for one cycle and `errCnt` increments.
  - The ACK handshake still occurs for bad frames.
- Undefined:
  - Parity is ignored and every frame is treated as good.
  - `parErr` and `errCnt` are tied to 0.
  - No parity XOR logic is synthesised.

## Test plan
- Reset, then `rxFlag` pulse with `rxData`=0x5A, `rxParity`=0 → `outValid`=1, `outData`=0x5A, `count`=1, `rxFlagClr` low exactly until `rxFlag` is sampled 0.
- Five good frames 0x01..0x05, `outReady`=0, DEPTH=4 → `count`=4, one `overrun` pulse on the fifth, then pops return 0x01..0x04 in order.
- With the macro, `rxData`=0x01, `rxParity`=0 → no push, one-cycle `parErr`, `errCnt`=1. Without the macro → 0x01 is pushed and `parErr` stays 0.
- FIFO full with `outReady`=1 during CAPTURE of 0xAA → push accepted, `count` stays 4, no `overrun`, 0xAA is last out.
- `rxFlag` held high for 20 cycles → exactly one push. `rst` asserted in ACK → all outputs return to reset values, `rxFlagClr`=1 immediately.
- 300 consecutive parity-bad frames with the macro → `errCnt` saturates at 255.
